// File: rtl/bus_mem_responder_if.sv
// Shared-bus request/response bundle between a bus master and the memory responder.
interface bus_mem_if;
   logic        i_bus_en;
   logic        i_wr_en;
   logic [31:0] i_wr_data;
   logic [31:0] i_addr;
   logic [3:0]  i_byte_en;
   logic        o_ack;
   logic [31:0] o_rd_data;
   logic        o_err;

   modport master (
      output i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en,
      input  o_ack, o_rd_data, o_err
   );

   modport slave (
      input  i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en,
      output o_ack, o_rd_data, o_err
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-RAM bus target: decodes one address window, acks each transfer once after a
// programmable wait, then ignores the bus for a holdoff so a stale request is not re-served.
module bus_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned HOLDOFF     = 2
) (
   input  logic     i_clk,
   input  logic     i_rst,
   bus_mem_if.slave bus
);
   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned WCW       = 4;
   localparam int unsigned HCW       = (HOLDOFF > 2) ? $clog2(HOLDOFF - 1) : 1;
   localparam int unsigned HOLD_INIT = (HOLDOFF > 1) ? HOLDOFF - 2 : 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
   logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic                    hit_q, hit_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [31:0]             wr_data_q, wr_data_d;
   logic [3:0]              byte_en_q, byte_en_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [31:0]             rd_data_q, rd_data_d;
   logic                    mem_we;

   logic [31:0] mem [DEPTH];

   // Window decode on the word address; out-of-window offsets wrap to large values and miss.
   logic [29:0] diff_c;
   logic        hit_c;
   logic        unused_addr_lsb;
   assign diff_c          = bus.i_addr[31:2] - BASE_ADDR[31:2];
   assign hit_c           = (diff_c >> DEPTH_LOG2) == '0;
   assign unused_addr_lsb = ^bus.i_addr[1:0];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         hold_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         hit_q      <= 1'b0;
         idx_q      <= '0;
         wr_data_q  <= '0;
         byte_en_q  <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         wr_en_q    <= wr_en_d;
         hit_q      <= hit_d;
         idx_q      <= idx_d;
         wr_data_q  <= wr_data_d;
         byte_en_q  <= byte_en_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Even with WAIT_CYCLES=0 one WAIT cycle (count already 0) separates capture from ack.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      hold_cnt_d = hold_cnt_q;
      wr_en_d    = wr_en_q;
      hit_d      = hit_q;
      idx_d      = idx_q;
      wr_data_d  = wr_data_q;
      byte_en_d  = byte_en_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rd_data_d  = '0;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.i_bus_en) begin
               wr_en_d    = bus.i_wr_en;
               hit_d      = hit_c;
               idx_d      = diff_c[DEPTH_LOG2-1:0];
               wr_data_d  = bus.i_wr_data;
               byte_en_d  = bus.i_byte_en;
               wait_cnt_d = WCW'(WAIT_CYCLES);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               err_d   = !hit_q;
               mem_we  = wr_en_q && hit_q && i_rst;
               if (!wr_en_q && hit_q) begin
                  rd_data_d = mem[idx_q];
               end
            end else begin
               wait_cnt_d = wait_cnt_q - WCW'(1);
            end
         end
         S_ACK: begin
            // The edge leaving ACK is the first ignored request sample of the holdoff.
            if (HOLDOFF > 1) begin
               hold_cnt_d = HCW'(HOLD_INIT);
               state_d    = S_HOLD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - HCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Byte-lane write port; contents intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_q[b]) begin
               mem[idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
            end
         end
      end
   end

   assign bus.o_ack     = ack_q;
   assign bus.o_err     = err_q;
   assign bus.o_rd_data = rd_data_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: vector table, corner sequences, random vs. model.
module tb_bus_mem_responder;
   localparam int unsigned D0_LOG2 = 6;
   localparam logic [31:0] BASE0   = 32'h0000_2000;
   localparam int unsigned W0      = 1;
   localparam int unsigned H0      = 2;
   localparam int unsigned D1_LOG2 = 4;
   localparam logic [31:0] BASE1   = 32'h0000_0000;
   localparam int unsigned W1      = 0;
   localparam int unsigned H1      = 3;
   localparam int unsigned DEPTH0  = 1 << D0_LOG2;

   logic clk;
   logic rst;

   bus_mem_if b0 ();
   bus_mem_if b1 ();

   bus_mem_responder #(.DEPTH_LOG2(D0_LOG2), .BASE_ADDR(BASE0), .WAIT_CYCLES(W0), .HOLDOFF(H0))
      dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
   bus_mem_responder #(.DEPTH_LOG2(D1_LOG2), .BASE_ADDR(BASE1), .WAIT_CYCLES(W1), .HOLDOFF(H1))
      dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [DEPTH0];

   typedef struct packed {
      logic        sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      int unsigned w, bw;
      w  = a >> 2;
      bw = BASE0 >> 2;
      return (w >= bw) && (w < bw + DEPTH0);
   endfunction

   function automatic int unsigned m_idx(input logic [31:0] a);
      return (a >> 2) - (BASE0 >> 2);
   endfunction

   function automatic logic get_ack(input logic sel);
      return sel ? b1.o_ack : b0.o_ack;
   endfunction
   function automatic logic get_err(input logic sel);
      return sel ? b1.o_err : b0.o_err;
   endfunction
   function automatic logic [31:0] get_rd(input logic sel);
      return sel ? b1.o_rd_data : b0.o_rd_data;
   endfunction

   task automatic drive(input logic sel, input logic en, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      if (!sel) begin
         b0.i_bus_en = en; b0.i_wr_en = wr; b0.i_addr = addr; b0.i_wr_data = data; b0.i_byte_en = be;
      end else begin
         b1.i_bus_en = en; b1.i_wr_en = wr; b1.i_addr = addr; b1.i_wr_data = data; b1.i_byte_en = be;
      end
   endtask

   // One full transfer: latency is counted in falling edges after the request is driven,
   // so a capture at edge k with ack after edge k+1+WAIT shows up at falling edge WAIT+2.
   task automatic do_txn(input logic sel, input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output logic [31:0] rd, output logic err);
      int lat;
      int exp_lat;
      exp_lat = sel ? int'(W1) + 2 : int'(W0) + 2;
      @(negedge clk);
      drive(sel, 1'b1, wr, addr, data, be);
      lat = 0;
      rd  = '0;
      err = 1'b0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         if (get_ack(sel)) begin
            lat = n;
            rd  = get_rd(sel);
            err = get_err(sel);
         end
      end
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      chk({name, " ack after pulse"}, {31'd0, get_ack(sel)}, 32'd0);
      chk({name, " rd_data after pulse"}, get_rd(sel), 32'd0);
      if (!sel && wr && m_hit(addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) model[m_idx(addr)][8*b +: 8] = data[8*b +: 8];
         end
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [18];
      logic [31:0] rd;
      logic        err;
      logic        wr;
      logic [31:0] addr, data, exp_rd;
      logic [3:0]  be;
      logic        exp_err;
      int          first, period;

      vecs[0]  = '{1'b0, 1'b1, 32'h2010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h2010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h2020, 32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'h2020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h2020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h2000, 32'h12345678, 4'hF, 32'h0,        1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h2100, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h2100, 32'h55555555, 4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 1'b0, 32'h2000, 32'h0,        4'hF, 32'h12345678, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h2010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h2013, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h1FFC, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 1'b1, 32'h20FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 1'b0, 32'h20FF, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 32'h0008, 32'hA5A55A5A, 4'hF, 32'h0,        1'b0};
      vecs[15] = '{1'b1, 1'b0, 32'h000B, 32'h0,        4'hF, 32'hA5A55A5A, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 32'h0040, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[17] = '{1'b1, 1'b1, 32'h0044, 32'h01020304, 4'hF, 32'h0,        1'b1};

      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(negedge clk);
      chk("reset ack0", {31'd0, b0.o_ack}, 32'd0);
      chk("reset err0", {31'd0, b0.o_err}, 32'd0);
      chk("reset rd0", b0.o_rd_data, 32'd0);
      chk("reset ack1", {31'd0, b1.o_ack}, 32'd0);
      chk("reset err1", {31'd0, b1.o_err}, 32'd0);
      chk("reset rd1", b1.o_rd_data, 32'd0);
      rst = 1'b1;

      // Give every word a known value so later reads never see uninitialised RAM.
      for (int i = 0; i < int'(DEPTH0); i++) begin
         do_txn(1'b0, $sformatf("init%0d", i), 1'b1, BASE0 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, rd, err);
      end

      for (int i = 0; i < 18; i++) begin
         do_txn(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, rd, err);
         chk($sformatf("vec%0d rd_data", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end

      // Request held high: one ack per WAIT+HOLDOFF+2 cycles, never back to back.
      first  = int'(W0) + 2;
      period = int'(W0) + int'(H0) + 2;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h2010, '0, 4'hF);
      for (int n = 1; n <= 20; n++) begin
         logic exp_ack;
         @(negedge clk);
         exp_ack = (n >= first) && (((n - first) % period) == 0);
         chk($sformatf("stream ack n%0d", n), {31'd0, b0.o_ack}, {31'd0, exp_ack});
         chk($sformatf("stream rd n%0d", n), b0.o_rd_data, exp_ack ? model[m_idx(32'h2010)] : 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (8) @(negedge clk);

      // Reset while a write waits: nothing acked, nothing written.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h2010, 32'h0BADF00D, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      for (int n = 2; n <= 5; n++) begin
         @(negedge clk);
         if (n == 3) rst = 1'b1;
         chk($sformatf("abort ack n%0d", n), {31'd0, b0.o_ack}, 32'd0);
      end
      do_txn(1'b0, "post-reset read", 1'b0, 32'h2010, '0, 4'hF, rd, err);
      chk("post-reset rd_data", rd, model[m_idx(32'h2010)]);
      chk("post-reset err", {31'd0, err}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         wr      = 1'($urandom_range(0, 1));
         addr    = 32'h1FF0 + 32'($urandom_range(0, 32'h12F));
         data    = $urandom;
         be      = 4'($urandom_range(0, 15));
         exp_err = !m_hit(addr);
         exp_rd  = (!wr && m_hit(addr)) ? model[m_idx(addr)] : 32'd0;
         do_txn(1'b0, $sformatf("rnd%0d", i), wr, addr, data, be, rd, err);
         chk($sformatf("rnd%0d rd_data", i), rd, exp_rd);
         chk($sformatf("rnd%0d err", i), {31'd0, err}, {31'd0, exp_err});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
